// File: rtl/xgmii_rs_fault.sv
// RS link fault handler: decodes rx fault sequences, runs the link fault FSM, overrides tx toward the PHY.
// Latency: 1 cycle rx->status and tx->tx_out; no backpressure (XGMII is free-running).
module xgmii_rs_fault #(
  parameter int C_COL_WINDOW = 128,
  parameter int C_SEQ_THRESH = 4
) (
  input  logic        clk156,
  input  logic        reset,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic [63:0] xgmii_txd,
  input  logic [7:0]  xgmii_txc,
  input  logic        clr_cnt,
  output logic [63:0] xgmii_txd_out,
  output logic [7:0]  xgmii_txc_out,
  output logic [1:0]  link_fault,
  output logic        linkup,
  output logic [15:0] local_fault_cnt,
  output logic [15:0] remote_fault_cnt
);

  localparam int SW = $clog2(C_SEQ_THRESH + 1);
  localparam int CW = $clog2(C_COL_WINDOW + 1);
  localparam logic [SW-1:0] SEQ_MAX = SW'(C_SEQ_THRESH);
  localparam logic [CW-1:0] COL_MAX = CW'(C_COL_WINDOW);
  localparam logic [63:0] IDLE_D = 64'h0707070707070707;
  localparam logic [63:0] RF_D   = 64'h0200009C0200009C;

  // 00 doubles as "no sequence seen" for last_type and "link OK" for the fault state
  typedef enum logic [1:0] {FLT_NONE = 2'b00, FLT_LOCAL = 2'b01, FLT_REMOTE = 2'b10} fault_t;

  fault_t          last_type, lf_q, t_n, lf_n, col_t;
  logic [SW-1:0]   seq_cnt, seq_n;
  logic [CW-1:0]   col_cnt, col_n;
  logic [31:0]     col_d;
  logic [3:0]      col_c;
  logic            ovr_active, ovr_n, mac_idle;
  logic [63:0]     txd_n;
  logic [7:0]      txc_n;

  always_comb begin
    t_n   = last_type;
    lf_n  = lf_q;
    seq_n = seq_cnt;
    col_n = col_cnt;
    col_d = '0;
    col_c = '0;
    col_t = FLT_NONE;
    for (int c = 0; c < 2; c++) begin
      col_d = xgmii_rxd[c*32 +: 32];
      col_c = xgmii_rxc[c*4 +: 4];
      col_t = FLT_NONE;
      if (col_c == 4'b0001 && col_d[23:0] == 24'h00009C) begin
        if (col_d[31:24] == 8'h01)
          col_t = FLT_LOCAL;
        else if (col_d[31:24] == 8'h02)
          col_t = FLT_REMOTE;
      end
      if (col_t != FLT_NONE) begin
        if (col_t != t_n) begin
          t_n   = col_t;
          seq_n = SW'(1);
        end else if (seq_n < SEQ_MAX) begin
          seq_n = seq_n + SW'(1);
        end
        col_n = '0;
        if (seq_n >= SEQ_MAX)
          lf_n = col_t;
      end else begin
        col_n = col_n + CW'(1);
        if (col_n == COL_MAX) begin
          lf_n  = FLT_NONE;
          seq_n = '0;
          col_n = '0;
          t_n   = FLT_NONE;
        end
      end
    end
  end

  // Tx select uses the registered fault state, so rx faults reach the PHY two edges later
  always_comb begin
    txd_n    = xgmii_txd;
    txc_n    = xgmii_txc;
    ovr_n    = ovr_active;
    mac_idle = (xgmii_txc == 8'hFF) && (xgmii_txd == IDLE_D);
    case (lf_q)
      FLT_LOCAL: begin
        txd_n = RF_D;
        txc_n = 8'h11;
        ovr_n = 1'b1;
      end
      FLT_REMOTE: begin
        txd_n = IDLE_D;
        txc_n = 8'hFF;
        ovr_n = 1'b1;
      end
      default: begin
        if (ovr_active && !mac_idle) begin
          txd_n = IDLE_D;
          txc_n = 8'hFF;
        end else begin
          ovr_n = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      last_type        <= FLT_NONE;
      lf_q             <= FLT_LOCAL;
      seq_cnt          <= '0;
      col_cnt          <= '0;
      ovr_active       <= 1'b1;
      linkup           <= 1'b0;
      xgmii_txd_out    <= IDLE_D;
      xgmii_txc_out    <= 8'hFF;
      local_fault_cnt  <= '0;
      remote_fault_cnt <= '0;
    end else begin
      last_type     <= t_n;
      lf_q          <= lf_n;
      seq_cnt       <= seq_n;
      col_cnt       <= col_n;
      ovr_active    <= ovr_n;
      linkup        <= (lf_n == FLT_NONE);
      xgmii_txd_out <= txd_n;
      xgmii_txc_out <= txc_n;
      if (clr_cnt)
        local_fault_cnt <= '0;
      else if (lf_n == FLT_LOCAL && lf_q != FLT_LOCAL && local_fault_cnt != 16'hFFFF)
        local_fault_cnt <= local_fault_cnt + 16'd1;
      if (clr_cnt)
        remote_fault_cnt <= '0;
      else if (lf_n == FLT_REMOTE && lf_q != FLT_REMOTE && remote_fault_cnt != 16'hFFFF)
        remote_fault_cnt <= remote_fault_cnt + 16'd1;
    end
  end

  assign link_fault = lf_q;

endmodule
